// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array blocks: accumulator width, drain
// states and the sign-magnitude to two's-complement conversion.
package systolic_pkg;

   localparam int ACC_W = 16;

   typedef enum logic [1:0] {CLEAR, IDLE, SHIFT} drain_state_t;

   // Q7.8 sign-magnitude to two's complement; negative zero folds to zero.
   function automatic logic [15:0] sm_to_tc(input logic [15:0] sm);
      logic signed [15:0] mag;
      mag = signed'({1'b0, sm[14:0]});
      return sm[15] ? -mag : mag;
   endfunction

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO buffering drained columns ahead of the downstream writer.
// Storage is not reset; the read port reads zero while empty.
module drain_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign push  = wr_en && !full;
   assign pop   = rd_en && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/systolic_drain.sv
// Drain controller: shifts accumulators out of the PE array, converts them to
// two's complement and streams one column per beat over valid/ready.
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4,
   localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   input  logic [ROWS*DATA_W-1:0] acc_in,
   output logic                   shift_out,
   output logic                   rst_output,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ROWS*DATA_W-1:0] out_data,
   output logic [CW-1:0]          out_col,
   output logic                   out_last
);

   localparam int DW = ROWS * ACC_W;
   localparam int FW = DW + CW + 1;

   drain_state_t      state_q;
   logic [CW-1:0]     col_q;
   logic              done_q;
   logic              clr_q;
   logic              busy_q;
   logic              last_col;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DW-1:0]     conv_p0;
   logic              vld_p0;
   logic [FW-1:0]     word_p0;
   logic [FW-1:0]     fifo_rd;

   assign last_col   = (col_q == CW'(COLS - 1));
   // The array only advances when the buffer can take the column it presents.
   assign shift_out  = (state_q == SHIFT) && !fifo_full;
   assign rst_output = clr_q;
   assign busy       = busy_q;
   assign done       = done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLEAR;
         col_q   <= '0;
         done_q  <= 1'b0;
         clr_q   <= 1'b1;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            CLEAR: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               clr_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
            IDLE: begin
               if (start) begin
                  state_q <= SHIFT;
                  col_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            SHIFT: begin
               if (shift_out) begin
                  col_q <= col_q + 1'b1;
                  if (last_col) begin
                     state_q <= CLEAR;
                     done_q  <= 1'b1;
                     clr_q   <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= CLEAR;
               clr_q   <= 1'b1;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   // Stage p0: convert the column at the array edge, push on the shift edge.
   always_comb begin
      conv_p0 = '0;
      for (int r = 0; r < ROWS; r++) begin
         conv_p0[r*ACC_W +: ACC_W] = sm_to_tc(acc_in[r*ACC_W +: ACC_W]);
      end
   end

   assign vld_p0  = shift_out;
   assign word_p0 = {conv_p0, col_q, last_col};

   drain_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (vld_p0),
      .wr_data (word_p0),
      .rd_en   (out_ready),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign {out_data, out_col, out_last} = fifo_rd;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: three configurations driven with an array model,
// checked against a queue of expected beats built from the conversion rules.
module tb_systolic_drain;

   typedef logic [34:0] beat_t;

   logic clk, rst;

   logic start_a, ready_a, busy_a, done_a, shift_a, rsto_a, valid_a, last_a;
   logic [31:0] acc_a, data_a;
   logic [1:0]  col_a;
   logic start_b, ready_b, busy_b, done_b, shift_b, rsto_b, valid_b, last_b;
   logic [31:0] acc_b, data_b;
   logic [1:0]  col_b;
   logic start_c, ready_c, busy_c, done_c, shift_c, rsto_c, valid_c, last_c;
   logic [31:0] acc_c, data_c;
   logic [0:0]  col_c;

   int nvec = 0;
   int errs = 0;

   logic [15:0] arr_a [2][4];
   logic [15:0] arr_b [2][4];
   int idx_a, idx_b;
   beat_t exp_a[$], got_a[$], exp_b[$], got_b[$];
   int nshift_a = 0, nshift_b = 0, ndone_a = 0, ndone_c = 0, nover = 0;

   systolic_drain #(.ROWS(2), .COLS(4), .DATA_W(16), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
      .acc_in(acc_a), .shift_out(shift_a), .rst_output(rsto_a),
      .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
      .out_col(col_a), .out_last(last_a));

   systolic_drain #(.ROWS(2), .COLS(4), .DATA_W(16), .FIFO_DEPTH(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
      .acc_in(acc_b), .shift_out(shift_b), .rst_output(rsto_b),
      .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
      .out_col(col_b), .out_last(last_b));

   systolic_drain #(.ROWS(2), .COLS(1), .DATA_W(16), .FIFO_DEPTH(4)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
      .acc_in(acc_c), .shift_out(shift_c), .rst_output(rsto_c),
      .out_valid(valid_c), .out_ready(ready_c), .out_data(data_c),
      .out_col(col_c), .out_last(last_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PE array model: each shift exposes the next column at the left edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_a <= 0;
         idx_b <= 0;
      end else begin
         if (shift_a) idx_a <= idx_a + 1; else if (rsto_a) idx_a <= 0;
         if (shift_b) idx_b <= idx_b + 1; else if (rsto_b) idx_b <= 0;
      end
   end

   always_comb begin
      acc_a = '0;
      acc_b = '0;
      for (int r = 0; r < 2; r++) begin
         if (idx_a < 4) acc_a[r*16 +: 16] = arr_a[r][idx_a[1:0]];
         if (idx_b < 4) acc_b[r*16 +: 16] = arr_b[r][idx_b[1:0]];
      end
   end

   always @(negedge clk) begin
      if (valid_a && ready_a) got_a.push_back({data_a, col_a, last_a});
      if (valid_b && ready_b) got_b.push_back({data_b, col_b, last_b});
      if (shift_a) nshift_a <= nshift_a + 1;
      if (shift_b) nshift_b <= nshift_b + 1;
      if (done_a)  ndone_a  <= ndone_a + 1;
      if (done_c)  ndone_c  <= ndone_c + 1;
      if ((shift_a && rsto_a) || (shift_b && rsto_b) || (shift_c && rsto_c))
         nover <= nover + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ref_conv(input logic [15:0] v);
      int m;
      m = int'(v) & 32'h7FFF;
      if (v >= 16'h8000) m = -m;
      return 16'(m);
   endfunction

   function automatic beat_t mk_beat(input logic [15:0] a [2][4], input int c);
      return {ref_conv(a[1][c]), ref_conv(a[0][c]), 2'(c), (c == 3)};
   endfunction

   function automatic logic [15:0] rand_acc();
      if ($urandom_range(0, 7) == 0) return 16'h8000;
      return 16'($urandom);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_rand_a();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) arr_a[r][c] = rand_acc();
      for (int c = 0; c < 4; c++) exp_a.push_back(mk_beat(arr_a, c));
   endtask

   task automatic wait_drain_a(input int max, input string nm);
      int n = 0;
      while ((busy_a !== 1'b0 || got_a.size() < exp_a.size()) && n < max) begin
         step();
         n++;
      end
      if (n >= max) begin
         nvec++; errs++;
         $display("FAIL %s timeout: got %0d beats, need %0d", nm, got_a.size(), exp_a.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      {start_a, start_b, start_c, ready_a, ready_b, ready_c} = '0;
      acc_c = '0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) begin arr_a[r][c] = '0; arr_b[r][c] = '0; end
      repeat (3) step();
      nvec++;
      if ({rsto_a, busy_a, shift_a, done_a, valid_a, last_a, col_a, data_a} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b0, 32'h0}) begin
         errs++;
         $display("FAIL reset_a got rst_output=%b busy=%b shift=%b done=%b valid=%b last=%b col=%0d data=%h",
                  rsto_a, busy_a, shift_a, done_a, valid_a, last_a, col_a, data_a);
      end
      nvec++;
      if ({rsto_b, rsto_c, valid_b, valid_c} !== 4'b1100) begin
         errs++;
         $display("FAIL reset_bc got %b need 1100", {rsto_b, rsto_c, valid_b, valid_c});
      end
      rst = 1'b0;
      #1;
      nvec++;
      if (rsto_a !== 1'b1 || busy_a !== 1'b1) begin
         errs++;
         $display("FAIL post_reset_clear got rst_output=%b busy=%b need 1 1", rsto_a, busy_a);
      end
      step();
      nvec++;
      if ({rsto_a, busy_a, shift_a, valid_a} !== 4'b0000) begin
         errs++;
         $display("FAIL reset_idle got %b need 0000", {rsto_a, busy_a, shift_a, valid_a});
      end
      repeat (4) step();
      nvec++;
      if (ndone_a !== 0 || ndone_c !== 0) begin
         errs++;
         $display("FAIL reset_done got %0d/%0d pulses need 0", ndone_a, ndone_c);
      end
   endtask

   task automatic test_basic();
      beat_t e, g;
      int d0 = ndone_a;
      for (int k = 0; k < 4; k++) begin
         arr_a[0][k] = 16'(256 * (k + 1));
         arr_a[1][k] = 16'h8080;
         exp_a.push_back(mk_beat(arr_a, k));
      end
      ready_a = 1'b1;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if ({shift_a, rsto_a, busy_a} !== 3'b101) begin
            errs++;
            $display("FAIL basic_shift cycle %0d got shift/rst_output/busy=%b need 101", k, {shift_a, rsto_a, busy_a});
         end
         step();
      end
      nvec++;
      if ({shift_a, rsto_a, done_a} !== 3'b011) begin
         errs++;
         $display("FAIL basic_clear got shift/rst_output/done=%b need 011", {shift_a, rsto_a, done_a});
      end
      step();
      nvec++;
      if ({busy_a, done_a, rsto_a} !== 3'b000) begin
         errs++;
         $display("FAIL basic_end got busy/done/rst_output=%b need 000", {busy_a, done_a, rsto_a});
      end
      wait_drain_a(20, "basic_drain");
      nvec++;
      if (got_a.size() < 4) begin
         errs++;
         $display("FAIL basic_count got %0d beats need 4", got_a.size());
      end else if (got_a[0][34:19] !== 16'hFF80 || got_a[1][18:3] !== 16'h0200 || got_a[3][0] !== 1'b1) begin
         errs++;
         $display("FAIL basic_values got row1=%h row0=%h last=%b need ff80 0200 1",
                  got_a[0][34:19], got_a[1][18:3], got_a[3][0]);
      end
      while (exp_a.size() > 0 && got_a.size() > 0) begin
         e = exp_a.pop_front(); g = got_a.pop_front(); nvec++;
         if (g !== e) begin errs++; $display("FAIL basic_beat got %h need %h", g, e); end
      end
      nvec++;
      if (ndone_a - d0 !== 1) begin
         errs++;
         $display("FAIL basic_done got %0d pulses need 1", ndone_a - d0);
      end
   endtask

   task automatic test_backpressure();
      beat_t e, g;
      int s0 = nshift_b;
      int n = 0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) arr_b[r][c] = rand_acc();
      for (int c = 0; c < 4; c++) exp_b.push_back(mk_beat(arr_b, c));
      ready_b = 1'b0;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      repeat (6) step();
      nvec++;
      if (nshift_b - s0 !== 2 || shift_b !== 1'b0) begin
         errs++;
         $display("FAIL bp_stall got %0d shifts, shift_out=%b need 2 0", nshift_b - s0, shift_b);
      end
      for (int i = 0; i < 3; i++) begin
         nvec++;
         if (valid_b !== 1'b1 || {data_b, col_b, last_b} !== exp_b[0]) begin
            errs++;
            $display("FAIL bp_hold got valid=%b beat=%h need 1 %h", valid_b, {data_b, col_b, last_b}, exp_b[0]);
         end
         step();
      end
      ready_b = 1'b1;
      while ((busy_b !== 1'b0 || got_b.size() < 4) && n < 30) begin step(); n++; end
      nvec++;
      if (got_b.size() !== 4 || nshift_b - s0 !== 4) begin
         errs++;
         $display("FAIL bp_count got %0d beats %0d shifts need 4 4", got_b.size(), nshift_b - s0);
      end
      while (exp_b.size() > 0 && got_b.size() > 0) begin
         e = exp_b.pop_front(); g = got_b.pop_front(); nvec++;
         if (g !== e) begin errs++; $display("FAIL bp_beat got %h need %h", g, e); end
      end
   endtask

   task automatic test_conversion();
      logic [15:0] v [5] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h8100};
      logic [15:0] x [5] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h8001, 16'hFF00};
      int d0 = ndone_c;
      bit seen;
      ready_c = 1'b1;
      for (int i = 0; i < 5; i++) begin
         acc_c = {v[(i + 1) % 5], v[i]};
         start_c = 1'b1;
         step();
         start_c = 1'b0;
         seen = 1'b0;
         for (int n = 0; n < 6 && !seen; n++) begin
            step();
            if (valid_c === 1'b1) begin
               seen = 1'b1;
               nvec++;
               if ({data_c, col_c, last_c} !== {x[(i + 1) % 5], x[i], 1'b0, 1'b1}) begin
                  errs++;
                  $display("FAIL conv %h got %h col=%0d last=%b need %h col=0 last=1",
                           v[i], data_c, col_c, last_c, {x[(i + 1) % 5], x[i]});
               end
            end
         end
         if (!seen) begin
            nvec++; errs++;
            $display("FAIL conv %h timeout: no beat", v[i]);
         end
         repeat (2) step();
      end
      nvec++;
      if (ndone_c - d0 !== 5) begin
         errs++;
         $display("FAIL conv_done got %0d pulses need 5", ndone_c - d0);
      end
   endtask

   task automatic test_back_to_back();
      beat_t e, g;
      int d0 = ndone_a;
      int s0 = nshift_a;
      ready_a = 1'b0;
      load_rand_a();
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      step();
      start_a = 1'b1;
      step();
      step();
      start_a = 1'b0;
      step();
      nvec++;
      if ({rsto_a, done_a, valid_a} !== 3'b111) begin
         errs++;
         $display("FAIL b2b_clear got rst_output/done/valid=%b need 111", {rsto_a, done_a, valid_a});
      end
      step();
      load_rand_a();
      start_a = 1'b1;
      ready_a = 1'b1;
      step();
      start_a = 1'b0;
      wait_drain_a(40, "b2b_drain");
      repeat (3) step();
      nvec++;
      if (got_a.size() !== 8 || ndone_a - d0 !== 2 || nshift_a - s0 !== 8) begin
         errs++;
         $display("FAIL b2b_count got %0d beats %0d done %0d shifts need 8 2 8",
                  got_a.size(), ndone_a - d0, nshift_a - s0);
      end
      while (exp_a.size() > 0 && got_a.size() > 0) begin
         e = exp_a.pop_front(); g = got_a.pop_front(); nvec++;
         if (g !== e) begin errs++; $display("FAIL b2b_beat got %h need %h", g, e); end
      end
   endtask

   task automatic test_random();
      beat_t e, g;
      int n;
      for (int d = 0; d < 8; d++) begin
         n = 0;
         while (busy_a !== 1'b0 && n < 60) begin
            ready_a = ($urandom_range(0, 3) != 0);
            step();
            n++;
         end
         if (n >= 60) begin
            nvec++; errs++;
            $display("FAIL rand_idle timeout in drain %0d", d);
         end
         load_rand_a();
         start_a = 1'b1;
         ready_a = ($urandom_range(0, 3) != 0);
         step();
         start_a = 1'b0;
         repeat ($urandom_range(0, 3)) begin
            ready_a = ($urandom_range(0, 3) != 0);
            step();
         end
      end
      ready_a = 1'b1;
      wait_drain_a(100, "rand_drain");
      nvec++;
      if (got_a.size() !== 32) begin
         errs++;
         $display("FAIL rand_count got %0d beats need 32", got_a.size());
      end
      while (exp_a.size() > 0 && got_a.size() > 0) begin
         e = exp_a.pop_front(); g = got_a.pop_front(); nvec++;
         if (g !== e) begin errs++; $display("FAIL rand_beat got %h need %h", g, e); end
      end
   endtask

   task automatic test_mid_reset();
      int d0 = ndone_a;
      ready_a = 1'b0;
      load_rand_a();
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      step();
      step();
      nvec++;
      if (valid_a !== 1'b1) begin
         errs++;
         $display("FAIL midrst_pre got valid=%b need 1", valid_a);
      end
      rst = 1'b1;
      #1;
      nvec++;
      if ({valid_a, rsto_a, shift_a, busy_a, done_a} !== 5'b01010) begin
         errs++;
         $display("FAIL midrst_flush got valid/rst_output/shift/busy/done=%b need 01010",
                  {valid_a, rsto_a, shift_a, busy_a, done_a});
      end
      exp_a.delete();
      step();
      rst = 1'b0;
      step();
      nvec++;
      if ({busy_a, rsto_a, valid_a} !== 3'b000 || ndone_a !== d0 || got_a.size() !== 0) begin
         errs++;
         $display("FAIL midrst_idle got busy/rst_output/valid=%b done=%0d beats=%0d need 000 0 0",
                  {busy_a, rsto_a, valid_a}, ndone_a - d0, got_a.size());
      end
   endtask

   task automatic test_exclusive();
      nvec++;
      if (nover !== 0) begin
         errs++;
         $display("FAIL exclusive got %0d cycles with shift_out and rst_output high need 0", nover);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_conversion();
      test_back_to_back();
      test_random();
      test_mid_reset();
      test_exclusive();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

endmodule
